// File: rtl/rsa_host_seq_if.sv
// Byte-stream and core-register-file signals between the RSA host sequencer
// and its neighbours (UART rx/tx and the exponentiation core).
interface rsa_host_seq_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       core_we_n;
    logic       core_oe_n;
    logic       core_start_n;
    logic [1:0] core_reg_sel;
    logic [4:0] core_addr;
    logic [7:0] core_wdata;
    logic [7:0] core_rdata;
    logic       core_ready;

    modport master (
        input  rx_valid, rx_data, tx_ready, core_rdata, core_ready,
        output rx_ready, tx_valid, tx_data, core_we_n, core_oe_n, core_start_n,
               core_reg_sel, core_addr, core_wdata
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, core_rdata, core_ready,
        input  rx_ready, tx_valid, tx_data, core_we_n, core_oe_n, core_start_n,
               core_reg_sel, core_addr, core_wdata
    );
endinterface

// File: rtl/rsa_host_seq.sv
// Loads modulus/base/exponent into the RSA core, launches it, waits with a
// timeout and streams the 32-byte result back out MSB first.
module rsa_host_seq #(
    parameter int TIMEOUT = 1000000,
    parameter int TMO_W   = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    rsa_host_seq_if.master       bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    typedef enum logic [3:0] {
        S_LOAD_N, S_LOAD_A, S_LOAD_E, S_START, S_ARM,
        S_WAIT, S_RD_REQ, S_RD_CAP, S_SEND, S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [4:0]       r_cnt, w_cnt_nxt;
    logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
    logic             r_we_n, w_we_n_nxt, r_oe_n, w_oe_n_nxt, r_start_n, w_start_n_nxt;
    logic [1:0]       r_sel, w_sel_nxt;
    logic [4:0]       r_addr, w_addr_nxt;
    logic [7:0]       r_wdata, w_wdata_nxt, r_tx_data, w_tx_data_nxt;
    logic             r_tx_valid, w_tx_valid_nxt, r_rx_ready, w_rx_ready_nxt;
    logic             r_busy, w_busy_nxt, r_done, w_done_nxt, r_err, w_err_nxt;
    logic             w_accept;

    // rx_ready is only ever high in a load state, so this is the load handshake
    assign w_accept = bus.rx_valid && r_rx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_LOAD_N;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_tmo_nxt      = r_tmo;
        w_we_n_nxt     = 1'b1;
        w_oe_n_nxt     = 1'b1;
        w_start_n_nxt  = 1'b1;
        w_sel_nxt      = r_sel;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_tx_valid_nxt = r_tx_valid;
        w_tx_data_nxt  = r_tx_data;
        w_err_nxt      = r_err;
        case (r_state)
            S_LOAD_N, S_LOAD_A, S_LOAD_E: begin
                if (w_accept) begin
                    w_we_n_nxt  = 1'b0;
                    w_addr_nxt  = r_cnt;
                    w_wdata_nxt = bus.rx_data;
                    w_err_nxt   = 1'b0;
                    w_cnt_nxt   = r_cnt - 5'd1;
                    case (r_state)
                        S_LOAD_N: w_sel_nxt = 2'd3;
                        S_LOAD_A: w_sel_nxt = 2'd1;
                        default:  w_sel_nxt = 2'd2;
                    endcase
                    if (r_cnt == 5'd0) begin
                        w_cnt_nxt = 5'd31;
                        case (r_state)
                            S_LOAD_N: w_state_nxt = S_LOAD_A;
                            S_LOAD_A: w_state_nxt = S_LOAD_E;
                            default:  w_state_nxt = S_START;
                        endcase
                    end
                end
            end
            S_START: begin
                w_start_n_nxt = 1'b0;
                w_state_nxt   = S_ARM;
            end
            S_ARM: begin
                w_tmo_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_ready) begin
                    w_state_nxt = S_RD_REQ;
                    w_cnt_nxt   = 5'd31;
                    w_oe_n_nxt  = 1'b0;
                    w_sel_nxt   = 2'd0;
                    w_addr_nxt  = 5'd31;
                end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = 5'd31;
                    w_state_nxt = S_LOAD_N;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            S_RD_REQ: w_state_nxt = S_RD_CAP;
            S_RD_CAP: begin
                w_tx_data_nxt  = bus.core_rdata;
                w_tx_valid_nxt = 1'b1;
                w_state_nxt    = S_SEND;
            end
            S_SEND: begin
                if (bus.tx_ready) begin
                    w_tx_valid_nxt = 1'b0;
                    if (r_cnt == 5'd0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt   = r_cnt - 5'd1;
                        w_oe_n_nxt  = 1'b0;
                        w_sel_nxt   = 2'd0;
                        w_addr_nxt  = r_cnt - 5'd1;
                        w_state_nxt = S_RD_REQ;
                    end
                end
            end
            S_DONE: begin
                w_cnt_nxt   = 5'd31;
                w_state_nxt = S_LOAD_N;
            end
            default: w_state_nxt = S_LOAD_N;
        endcase
        w_done_nxt     = (w_state_nxt == S_DONE);
        w_rx_ready_nxt = (w_state_nxt == S_LOAD_N) || (w_state_nxt == S_LOAD_A) ||
                         (w_state_nxt == S_LOAD_E);
        w_busy_nxt     = !((w_state_nxt == S_LOAD_N) && (w_cnt_nxt == 5'd31));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= 5'd31;
            r_tmo      <= '0;
            r_we_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_start_n  <= 1'b1;
            r_sel      <= 2'd0;
            r_addr     <= 5'd0;
            r_wdata    <= 8'd0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_tmo      <= w_tmo_nxt;
            r_we_n     <= w_we_n_nxt;
            r_oe_n     <= w_oe_n_nxt;
            r_start_n  <= w_start_n_nxt;
            r_sel      <= w_sel_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_rx_ready <= w_rx_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bus.rx_ready     = r_rx_ready;
    assign bus.tx_valid     = r_tx_valid;
    assign bus.tx_data      = r_tx_data;
    assign bus.core_we_n    = r_we_n;
    assign bus.core_oe_n    = r_oe_n;
    assign bus.core_start_n = r_start_n;
    assign bus.core_reg_sel = r_sel;
    assign bus.core_addr    = r_addr;
    assign bus.core_wdata   = r_wdata;
    assign busy             = r_busy;
    assign done             = r_done;
    assign err              = r_err;
endmodule

// File: tb/tb_rsa_host_seq.sv
// Bench for rsa_host_seq: random operand streams, a behavioural RSA core and
// an expected-write / expected-result model derived from the load order.
module tb_rsa_host_seq;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy, done, err;

    rsa_host_seq_if bus();

    rsa_host_seq #(.TIMEOUT(TMO), .TMO_W(20)) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Core model: registered read data, ready a fixed delay after the start pulse
    int rdy_dly    = 50;
    bit core_stuck = 1'b0;
    int rdy_cnt    = 0;
    always @(posedge clk) begin
        if (reset) begin
            bus.core_ready <= 1'b0;
            bus.core_rdata <= 8'h00;
            rdy_cnt        <= 0;
        end else begin
            if (!bus.core_oe_n) bus.core_rdata <= {3'b000, bus.core_addr} ^ 8'hA5;
            if (!bus.core_start_n) begin
                bus.core_ready <= 1'b0;
                rdy_cnt        <= rdy_dly;
            end else if (rdy_cnt > 0) begin
                rdy_cnt <= rdy_cnt - 1;
                if (rdy_cnt == 1 && !core_stuck) bus.core_ready <= 1'b1;
            end
        end
    end

    // Observation log, sampled mid-cycle
    logic [14:0] wr_log[$];
    logic [7:0]  tx_log[$];
    int oe_cnt, start_cnt, start_ok, done_cnt, viol_excl, viol_we, viol_hold;
    int cyc = 0, start_cyc = 0, err_cyc = -1;
    logic acc_prev = 1'b0, txw_prev = 1'b0, we_prev = 1'b1;
    logic [7:0] txd_prev = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (bus.core_we_n !== !acc_prev) viol_we++;
            if (!bus.core_we_n) wr_log.push_back({bus.core_reg_sel, bus.core_addr, bus.core_wdata});
            if (!bus.core_oe_n) oe_cnt++;
            if (!bus.core_start_n) begin
                start_cnt++;
                start_cyc = cyc;
                if (!we_prev && wr_log.size() == 96) start_ok++;
                if (!bus.core_we_n || !bus.core_oe_n) viol_excl++;
            end
            if (!bus.core_we_n && !bus.core_oe_n) viol_excl++;
            if (bus.tx_valid && bus.tx_ready) tx_log.push_back(bus.tx_data);
            if (txw_prev && !(bus.tx_valid && bus.tx_data == txd_prev)) viol_hold++;
            if (done) done_cnt++;
            if (err && err_cyc < 0) err_cyc = cyc;
        end
        acc_prev = bus.rx_valid && bus.rx_ready && !reset;
        txw_prev = bus.tx_valid && !bus.tx_ready && !reset;
        txd_prev = bus.tx_data;
        we_prev  = bus.core_we_n;
    end

    logic [7:0] stim[96];

    task automatic clear_obs();
        wr_log.delete();
        tx_log.delete();
        oe_cnt = 0; start_cnt = 0; start_ok = 0; done_cnt = 0;
        viol_excl = 0; viol_we = 0; viol_hold = 0; err_cyc = -1;
    endtask

    task automatic check_reset(input string tag);
        chk(tag, {bus.core_we_n, bus.core_oe_n, bus.core_start_n, bus.core_reg_sel,
                  bus.core_addr, bus.core_wdata, bus.rx_ready, bus.tx_valid, bus.tx_data,
                  busy, done, err}, {3'b111, 28'd0});
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit ok = 1'b0;
        int t = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = bus.rx_ready;
            @(posedge clk); #1;
            t++;
        end
        bus.rx_valid = 1'b0;
        chk("rx_accept", ok, 1);
    endtask

    task automatic load_stream(input int gap);
        for (int i = 0; i < 96; i++) begin
            push_byte(stim[i]);
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_done(input int lim, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < lim && !ok; t++) begin
            if (rnd) bus.tx_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok = done;
            @(posedge clk); #1;
        end
        bus.tx_ready = 1'b1;
    endtask

    // Reference: 32 bytes each of modulus (sel 3), base (sel 1), exponent (sel 2),
    // each operand written from address 31 down to 0; result read 31 down to 0.
    function automatic logic [14:0] exp_write(input int i);
        logic [1:0] sel;
        logic [4:0] addr;
        case (i / 32)
            0:       sel = 2'd3;
            1:       sel = 2'd1;
            default: sel = 2'd2;
        endcase
        addr = 5'(31 - (i % 32));
        return {sel, addr, stim[i]};
    endfunction

    task automatic check_run(input string tag);
        logic [31:0] o;
        chk({tag, "_nwr"}, wr_log.size(), 96);
        for (int i = 0; i < 96; i++) begin
            o = 'x;
            if (i < wr_log.size()) o = 32'(wr_log[i]);
            chk({tag, "_wr"}, o, 32'(exp_write(i)));
        end
        chk({tag, "_ntx"}, tx_log.size(), 32);
        for (int k = 0; k < 32; k++) begin
            o = 'x;
            if (k < tx_log.size()) o = 32'(tx_log[k]);
            chk({tag, "_tx"}, o, 32'(8'(31 - k) ^ 8'hA5));
        end
        chk({tag, "_start_cnt"}, start_cnt, 1);
        chk({tag, "_start_after_wr"}, start_ok, 1);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_oe_cnt"}, oe_cnt, 32);
        chk({tag, "_excl"}, viol_excl, 0);
        chk({tag, "_we_timing"}, viol_we, 0);
        chk({tag, "_tx_hold"}, viol_hold, 0);
    endtask

    initial begin
        bit ok;
        int oe0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        clear_obs();

        // reset values and rx_ready rising one clock after release
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst_init");
        reset = 1'b0;
        @(negedge clk);
        chk("rxrdy_before_clk", bus.rx_ready, 0);
        @(negedge clk);
        chk("rxrdy_after_clk", bus.rx_ready, 1);
        chk("busy_idle", busy, 0);
        @(posedge clk); #1;

        // ordered back-to-back load and full readout
        for (int i = 0; i < 96; i++) stim[i] = 8'(i);
        clear_obs();
        load_stream(0);
        @(negedge clk);
        chk("seq_rxrdy_low", bus.rx_ready, 0);
        chk("seq_busy", busy, 1);
        @(posedge clk); #1;
        wait_done(600, 1'b0, ok);
        chk("seq_done_seen", ok, 1);
        @(negedge clk);
        chk("seq_rxrdy_after_done", bus.rx_ready, 1);
        chk("seq_done_single", done, 0);
        chk("seq_busy_after_done", busy, 0);
        check_run("seq");
        @(posedge clk); #1;

        // sparse random load, backpressure on the first result byte
        for (int i = 0; i < 96; i++) stim[i] = 8'($urandom);
        clear_obs();
        bus.tx_ready = 1'b0;
        load_stream(2);
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = bus.tx_valid;
        end
        chk("bp_tx_valid_seen", ok, 1);
        oe0 = oe_cnt;
        for (int k = 0; k < 5; k++) begin
            chk("bp_tx_valid", bus.tx_valid, 1);
            chk("bp_tx_data", bus.tx_data, 8'hBA);
            @(negedge clk);
        end
        chk("bp_no_oe", oe_cnt, oe0);
        @(posedge clk); #1;
        wait_done(1500, 1'b1, ok);
        chk("bp_done_seen", ok, 1);
        check_run("sparse");
        @(posedge clk); #1;

        // timeout: the core never reports ready
        for (int i = 0; i < 96; i++) stim[i] = 8'($urandom);
        clear_obs();
        core_stuck = 1'b1;
        load_stream(0);
        ok = 1'b0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clk);
            ok = err;
        end
        chk("tmo_err_seen", ok, 1);
        chk("tmo_rxrdy", bus.rx_ready, 1);
        chk("tmo_busy", busy, 0);
        @(posedge clk); #1;
        // start_n is low in the cycle before the first wait cycle; err shows
        // the cycle after the TIMEOUT-th wait cycle
        chk("tmo_latency", err_cyc - start_cyc, TMO + 1);
        chk("tmo_no_oe", oe_cnt, 0);
        chk("tmo_no_tx", tx_log.size(), 0);
        chk("tmo_nwr", wr_log.size(), 96);
        repeat (3) @(negedge clk);
        chk("tmo_err_sticky", err, 1);
        @(posedge clk); #1;
        core_stuck = 1'b0;
        push_byte(8'h77);
        @(negedge clk);
        chk("tmo_err_cleared", err, 0);
        @(posedge clk); #1;

        // reset after 40 loaded bytes, then a fresh stream
        for (int i = 0; i < 39; i++) push_byte(8'($urandom));
        #2;
        reset = 1'b1;
        #1;
        check_reset("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 96; i++) stim[i] = 8'($urandom);
        clear_obs();
        load_stream(0);
        wait_done(600, 1'b0, ok);
        chk("rerun_done_seen", ok, 1);
        check_run("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rsa_host_seq.md
Name: rsa_host_seq

Overview:
- Host-side sequencer directly upstream of the RSA exponentiation core; also its downstream drain.
- Accepts a 96-byte operand stream from the UART receiver: modulus, base, exponent, MSB byte first.
- Writes the operands into the core's byte-addressed register file, launches the core and waits for completion.
- Reads back the 32-byte result and emits it MSB first on a valid/ready byte stream toward the UART transmitter.

Parameters:
TIMEOUT, 1000000, max cycles spent in WAIT before abort with err
TMO_W, 20, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous active-high reset
rx_valid  in  1  input byte valid
rx_data  in  8  input byte
rx_ready  out  1  byte accepted when rx_valid&&rx_ready
tx_valid  out  1  result byte valid
tx_data  out  8  result byte
tx_ready  in  1  downstream accepts tx byte
core_we_n  out  1  core write strobe, active low, one cycle per byte
core_oe_n  out  1  core read strobe, active low
core_start_n  out  1  core launch, active-low one-cycle pulse
core_reg_sel  out  2  3=modulus, 1=base, 2=exponent, 0=result
core_addr  out  5  byte index, 0=LSB byte
core_wdata  out  8  write data to core
core_rdata  in  8  core read data, registered in core (1-cycle latency)
core_ready  in  1  core done/idle indication, high = result valid
busy  out  1  high in any state except LOAD_N before first byte
done  out  1  one-cycle pulse after last result byte accepted
err  out  1  sticky timeout flag, cleared on next accepted rx byte or reset

Behaviour:
- Reset (async, immediate):
  - state=LOAD_N, byte counter=31.
  - All outputs: core_we_n=1, core_oe_n=1, core_start_n=1, core_reg_sel=0, core_addr=0, core_wdata=0.
  - rx_ready=0, tx_valid=0, tx_data=0, busy=0, done=0, err=0.
  - rx_ready rises on the first clock after reset release.
- All outputs are registered; no combinational path from input to output.
- States: LOAD_N, LOAD_A, LOAD_E, START, ARM, WAIT, RD_REQ, RD_CAP, SEND, DONE.
- LOAD_N/LOAD_A/LOAD_E:
  - rx_ready=1.
  - Each accepted byte produces, on the next cycle only:
    - core_we_n=0;
    - core_reg_sel = 3, 1 or 2 respectively;
    - core_addr = counter value at acceptance;
    - core_wdata = byte.
  - The counter decrements 31→0. At acceptance with counter=0 the state advances and the counter reloads to 31.
  - Back-to-back bytes produce back-to-back write cycles.
  - Gaps in rx_valid leave core_we_n=1.
- LOAD_E→START:
  - rx_ready=0 from the cycle after the 96th acceptance.
  - START drives core_start_n=0 for exactly one cycle, coincident with the final write's cycle+1.
- ARM: one cycle, start_n back to 1, timeout counter cleared. Then WAIT.
- WAIT:
  - Counter increments each cycle.
  - core_ready=1 sampled → RD_REQ with counter=31.
  - Counter reaching TIMEOUT → err=1, abort to LOAD_N (no readout, counter=31).
- RD_REQ: core_oe_n=0, core_reg_sel=0, core_addr=counter for one cycle.
- RD_CAP: core_oe_n=1; tx_data<=core_rdata, tx_valid<=1 at end of this cycle; then SEND.
- SEND:
  - tx_valid/tx_data held stable while tx_ready=0.
  - On tx_valid&&tx_ready: tx_valid<=0.
  - If counter=0 → DONE; else counter-1 and back to RD_REQ.
  - Minimum 3 cycles per result byte.
- DONE: done=1 for one cycle, return to LOAD_N (rx_ready=1 next cycle).
- core_we_n and core_oe_n are never low in the same cycle. core_start_n is never low while either strobe is low.
- rx bytes arriving outside LOAD states are not accepted (rx_ready=0); no buffering.
- Reset mid-operation aborts immediately: a partially loaded core is not cleared, and the next stream overwrites all 96 bytes.
- err behaves as a sticky flag per its port definition; otherwise it does not block new loads.

Test Plan:
- Load order:
  - Stimulus: stream bytes 0x00..0x5F back-to-back.
  - Writes: (sel3,addr31,0x00)…(sel3,addr0,0x1F), (sel1,addr31,0x20)…(sel1,addr0,0x3F), (sel2,addr31,0x40)…(sel2,addr0,0x5F).
  - One start_n low cycle immediately after the last write; rx_ready=0 thereafter.
- Sparse input: rx_valid high every 3rd cycle → identical 96 writes, core_we_n low only the cycle after each acceptance.
- Readout:
  - Stimulus: core model asserts core_ready 50 cycles after start, rdata=addr^0xA5, tx_ready=1.
  - Required tx sequence: 0xBA (addr31), 0xBB, …, 0xA5 (addr0).
  - done pulse once after the 32nd byte; then rx_ready=1.
- Backpressure: tx_ready held 0 for 5 cycles on byte 0 → tx_valid=1, tx_data=0xBA stable; no further oe_n pulses until accepted.
- Timeout: TIMEOUT=100, core_ready stuck 0 → err=1 on the 100th WAIT cycle, state LOAD_N, no oe_n/tx activity; next accepted byte clears err.
- Reset: assert reset after 40 loaded bytes → all outputs at reset values immediately; a fresh 96-byte stream completes correctly.
